fir_out_requant: RTL and testbench
==================================

FIR_OUT_REQUANT -- requirements
Module: fir_out_requant

Interface
REQ-001 Parameter SHIFT, default 7: right-shift applied to the 18-bit FIR sum before narrowing.
REQ-002 Parameter DECIM, default 2: decimation ratio, legal range 1..16.
REQ-003 Parameter DEPTH, default 4: output FIFO depth, power of two, 2..16.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  one-cycle strobe marking a new FIR sum on in_data.
REQ-007 in_data  input  18  signed FIR sum, two's complement.
REQ-008 out_valid  output  1  FIFO head word present on out_data.
REQ-009 out_ready  input  1  consumer accepts head word when out_valid and out_ready are both high.
REQ-010 out_data  output  8  signed requantized sample.
REQ-011 fill  output  5  current FIFO occupancy, 0..DEPTH.
REQ-012 drop  output  1  one-cycle pulse when a kept sample is discarded because the FIFO is full.
REQ-013 ovf  output  1  sticky flag, set on any saturation event, cleared only by reset.

Function
REQ-014 Decimation counter dcnt, range 0..DECIM-1, shall advance on each in_valid and wrap to 0 after DECIM-1.
REQ-015 A sample shall be kept only when in_valid is high and dcnt==0; all other samples are ignored.
REQ-016 Rounding shall be round-half-up: the block adds 2^(SHIFT-1) in a 19-bit signed intermediate, then arithmetic-shifts right by SHIFT.
REQ-017 The narrowing of the rounded value to 8 bits shall follow REQ-030/REQ-031.
REQ-018 Stage 1 shall register the 8-bit result and a kept flag in the cycle after in_valid.
REQ-019 Stage 2 shall write the registered result into the FIFO on the following edge.
REQ-020 Latency: in_valid at edge N with an empty FIFO shall give out_valid high after edge N+2, with out_data equal to the result.
REQ-021 The FIFO shall be first-word-fall-through; read and write pointers shall wrap modulo DEPTH.
REQ-022 When the FIFO is empty: out_valid=0 and out_data=0.
REQ-023 A write when fill==DEPTH and no pop occurs in the same cycle shall be discarded, drop shall pulse high, and FIFO contents shall be unchanged.
REQ-024 A write and a pop in the same cycle with fill==DEPTH shall both be accepted; fill stays at DEPTH and drop stays 0.
REQ-025 A write and a pop in the same cycle with 0<fill<DEPTH shall leave fill unchanged.
REQ-026 Holding out_ready low shall hold out_data and out_valid stable.

Reset
REQ-027 While rst is low, all outputs shall be 0: out_valid, out_data, fill, drop, ovf.
REQ-028 While rst is low, dcnt, both pipeline stages and both FIFO pointers shall be 0.
REQ-029 Reset taken mid-operation shall discard FIFO contents immediately without waiting for a clock edge; the first in_valid after reset release is kept.

Configuration
REQ-030 With macro FIR_OUT_SAT_EN defined, the rounded value shall be clamped to [-128,127], and ovf shall be set whenever clamping occurs.
REQ-031 Without FIR_OUT_SAT_EN, out_data shall be the low 8 bits of the rounded value (wrap), and ovf shall stay 0.

Verification
REQ-032 SHIFT=7, DECIM=1, FIFO empty, in_data=1000 -> out_data=8; in_data=-1000 -> out_data=-8. Both appear 2 cycles after in_valid.
REQ-033 in_data=131071:
- with FIR_OUT_SAT_EN -> out_data=127, ovf=1
- without -> out_data=0, ovf=0
- in_data=-131072 with FIR_OUT_SAT_EN -> out_data=-128.
REQ-034 DECIM=2, inputs 1280, 2560, 3840, 5120 -> outputs 10, 30 only, in that order.
REQ-035 DECIM=1, out_ready=0, five samples 128..640 step 128:
- fill=4 and drop pulses once on the 5th sample
- then out_ready=1 -> outputs 1, 2, 3, 4.
REQ-036 Full FIFO with a simultaneous pop and write -> fill stays 4, drop=0, and the written sample appears last.
REQ-037 fill=3, rst driven low between edges -> fill=0 and out_valid=0 immediately; after release, the next sample outputs normally.

Source files
------------

// File: rtl/fir_out_requant.sv
// FIR output requantizer: decimate, round-half-up, narrow to 8 bits, buffer in a FWFT FIFO.
// Define FIR_OUT_SAT_EN for clamping to [-128,127] with a sticky ovf flag; default wraps.
module fir_out_requant #(
   parameter int SHIFT = 7,
   parameter int DECIM = 2,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic signed [17:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [7:0]  out_data,
   output logic [4:0]         fill,
   output logic               drop,
   output logic               ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] DCNT_LAST = 4'(DECIM - 1);
   localparam logic [4:0] FILL_MAX = 5'(DEPTH);
   localparam logic signed [18:0] HALF = 19'sd1 <<< (SHIFT - 1);

   function automatic logic signed [18:0] round_shift(input logic signed [17:0] x);
      logic signed [18:0] biased;
      biased = $signed({x[17], x}) + HALF;
      return biased >>> SHIFT;
   endfunction

   function automatic logic [7:0] narrow8(input logic signed [18:0] r);
`ifdef FIR_OUT_SAT_EN
      if (r > 19'sd127) return 8'h7f;
      if (r < -19'sd128) return 8'h80;
`endif
      return r[7:0];
   endfunction

`ifdef FIR_OUT_SAT_EN
   function automatic logic sat_hit(input logic signed [18:0] r);
      return (r > 19'sd127) || (r < -19'sd128);
   endfunction
`endif

   logic [3:0]         dcnt_q, dcnt_d;
   logic               keep;
   logic signed [18:0] rnd;
   logic [7:0]         res_p1_q;
   logic               kept_p1_q;
   logic [7:0]         mem_q [DEPTH];
   logic [AW-1:0]      wptr_q, rptr_q;
   logic [4:0]         fill_q, fill_d;
   logic               drop_q, drop_d;
   logic               pop, full, wr_en;

   assign keep = in_valid && (dcnt_q == 4'd0);
   assign rnd  = round_shift(in_data);

   always_comb begin
      dcnt_d = dcnt_q;
      if (in_valid) dcnt_d = (dcnt_q == DCNT_LAST) ? 4'd0 : dcnt_q + 4'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dcnt_q <= '0;
      else      dcnt_q <= dcnt_d;
   end

   // Stage 1: registered requantized sample and its kept flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_p1_q  <= '0;
         kept_p1_q <= 1'b0;
      end else begin
         kept_p1_q <= keep;
         if (keep) res_p1_q <= narrow8(rnd);
      end
   end

`ifdef FIR_OUT_SAT_EN
   logic ovf_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      ovf_q <= 1'b0;
      else if (keep && sat_hit(rnd)) ovf_q <= 1'b1;
   end
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   // Stage 2: FIFO write; when full, a same-cycle pop frees the slot being written
   assign out_valid = (fill_q != 5'd0);
   assign pop       = out_valid && out_ready;
   assign full      = (fill_q == FILL_MAX);
   assign wr_en     = kept_p1_q && (!full || pop);
   assign drop_d    = kept_p1_q && full && !pop;
   assign fill_d    = fill_q + 5'(wr_en) - 5'(pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q] <= res_p1_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         fill_q <= '0;
         drop_q <= 1'b0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + AW'(1);
         if (pop)   rptr_q <= rptr_q + AW'(1);
         fill_q <= fill_d;
         drop_q <= drop_d;
      end
   end

   assign out_data = out_valid ? $signed(mem_q[rptr_q]) : 8'sd0;
   assign fill     = fill_q;
   assign drop     = drop_q;
endmodule

// File: tb/tb_fir_out_requant.sv
// Bench for fir_out_requant: directed vectors on a DECIM=1 instance, random traffic on a DECIM=2 instance.
module tb_fir_out_requant;
   localparam int SHIFT  = 7;
   localparam int DEPTH  = 4;
   localparam int DECIM2 = 2;
`ifdef FIR_OUT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               in_valid = 1'b0;
   logic               out_ready = 1'b0;
   logic signed [17:0] in_data = '0;

   logic               a_ovalid, a_drop, a_ovf;
   logic signed [7:0]  a_odata;
   logic [4:0]         a_fill;
   logic               b_ovalid, b_drop, b_ovf;
   logic signed [7:0]  b_odata;
   logic [4:0]         b_fill;

   fir_out_requant #(.SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .out_valid(a_ovalid), .out_ready(out_ready), .out_data(a_odata),
      .fill(a_fill), .drop(a_drop), .ovf(a_ovf));

   fir_out_requant #(.SHIFT(SHIFT), .DECIM(DECIM2), .DEPTH(DEPTH)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .out_valid(b_ovalid), .out_ready(out_ready), .out_data(b_odata),
      .fill(b_fill), .drop(b_drop), .ovf(b_ovf));

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      rst       = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   // Reference requantizer: floor((x + 2^(SHIFT-1)) / 2^SHIFT), then clamp or wrap to 8 bits.
   function automatic int ref_req(input int x, output bit s);
      int n, d, r;
      n = x + 2 ** (SHIFT - 1);
      d = 2 ** SHIFT;
      r = n / d;
      if ((n % d != 0) && (n < 0)) r--;
      s = 1'b0;
      if (SAT) begin
         if (r > 127) begin r = 127; s = 1'b1; end
         else if (r < -128) begin r = -128; s = 1'b1; end
      end else begin
         r = r & 255;
         if (r > 127) r -= 256;
      end
      return r;
   endfunction

   typedef struct {
      int din;
      int dout;
      int dovf;
   } vec_t;

   vec_t tbl[9];
   int   exp36[4];
   int   drops;
   int   q[$];
   bit   pv, movf, mdrop, mpop, mpush, s;
   int   pval, cnt;

   initial begin
      tbl = '{
         '{1000,    8,                 0},
         '{-1000,   -8,                0},
         '{63,      0,                 0},
         '{64,      1,                 0},
         '{-64,     0,                 0},
         '{-65,     -1,                0},
         '{131071,  SAT ? 127 : 0,     int'(SAT)},
         '{-131072, SAT ? -128 : 0,    int'(SAT)},
         '{16383,   SAT ? 127 : -128,  int'(SAT)}
      };
      exp36 = '{2, 3, 4, 6};

      // Outputs while held in reset, before any clock edge
      #2;
      check("rst a_valid", int'(a_ovalid), 0);
      check("rst a_data",  int'(a_odata),  0);
      check("rst a_fill",  int'(a_fill),   0);
      check("rst a_drop",  int'(a_drop),   0);
      check("rst a_ovf",   int'(a_ovf),    0);
      check("rst b_valid", int'(b_ovalid), 0);
      do_reset();

      // Table vectors, DECIM=1: latency of two edges, then pop
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_data  = 18'(tbl[i].din);
         step();
         in_valid = 1'b0;
         check($sformatf("tbl%0d early_valid", i), int'(a_ovalid), 0);
         step();
         check($sformatf("tbl%0d valid", i), int'(a_ovalid), 1);
         check($sformatf("tbl%0d data", i),  int'(a_odata),  tbl[i].dout);
         check($sformatf("tbl%0d ovf", i),   int'(a_ovf),    tbl[i].dovf);
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check($sformatf("tbl%0d empty", i), int'(a_ovalid), 0);
         check($sformatf("tbl%0d zero", i),  int'(a_odata),  0);
      end

      // Decimation by 2 keeps the 1st and 3rd samples
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         in_valid = 1'b1;
         in_data  = 18'(1280 * k);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      check("decim fill",  int'(b_fill),  2);
      check("decim first", int'(b_odata), 10);
      out_ready = 1'b1;
      step();
      check("decim second", int'(b_odata), 30);
      step();
      check("decim empty", int'(b_ovalid), 0);
      out_ready = 1'b0;

      // Overfill with out_ready low: one drop, oldest four kept
      do_reset();
      drops = 0;
      for (int k = 1; k <= 5; k++) begin
         in_valid = 1'b1;
         in_data  = 18'(128 * k);
         step();
         drops += int'(a_drop);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         drops += int'(a_drop);
      end
      check("ovfill drops", drops, 1);
      check("ovfill fill",  int'(a_fill), 4);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("ovfill out%0d", k), int'(a_odata), k);
         step();
      end
      check("ovfill empty", int'(a_ovalid), 0);
      out_ready = 1'b0;

      // Full FIFO with a pop and a write on the same edge
      for (int k = 1; k <= 4; k++) begin
         in_valid = 1'b1;
         in_data  = 18'(128 * k);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      check("fullrw prefill", int'(a_fill), 4);
      in_valid = 1'b1;
      in_data  = 18'sd768;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("fullrw fill", int'(a_fill), 4);
      check("fullrw drop", int'(a_drop), 0);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("fullrw out%0d", k), int'(a_odata), exp36[k]);
         step();
      end
      check("fullrw empty", int'(a_ovalid), 0);
      out_ready = 1'b0;

      // Asynchronous reset mid-operation
      for (int k = 1; k <= 3; k++) begin
         in_valid = 1'b1;
         in_data  = 18'(128 * k);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      check("arst prefill", int'(a_fill), 3);
      #2;
      rst = 1'b0;
      #1;
      check("arst fill",  int'(a_fill),   0);
      check("arst valid", int'(a_ovalid), 0);
      check("arst data",  int'(a_odata),  0);
      step();
      rst = 1'b1;
      in_valid = 1'b1;
      in_data  = 18'sd1000;
      step();
      in_valid = 1'b0;
      step();
      check("arst a_valid", int'(a_ovalid), 1);
      check("arst a_data",  int'(a_odata),  8);
      check("arst a_ovf",   int'(a_ovf),    0);
      check("arst b_valid", int'(b_ovalid), 1);
      check("arst b_data",  int'(b_odata),  8);

      // Random traffic on the DECIM=2 instance against a queue model
      do_reset();
      q.delete();
      pv   = 1'b0;
      pval = 0;
      cnt  = 0;
      movf = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         in_valid = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 3) == 0) in_data = 18'($urandom);
         else in_data = 18'(int'($urandom_range(0, 8191)) - 4096);
         if ((cyc / 250) % 2 == 0) out_ready = ($urandom_range(0, 3) == 0);
         else out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         mpop  = (q.size() > 0) && out_ready;
         mpush = pv;
         mdrop = mpush && (q.size() == DEPTH) && !mpop;
         if (mpop) void'(q.pop_front());
         if (mpush && !mdrop) q.push_back(pval);
         pv = in_valid && (cnt % DECIM2 == 0);
         if (pv) begin
            pval = ref_req(int'(in_data), s);
            if (s) movf = 1'b1;
         end
         if (in_valid) cnt++;
         #1;
         check("rnd valid", int'(b_ovalid), int'(q.size() > 0));
         check("rnd data",  int'(b_odata),  (q.size() > 0) ? q[0] : 0);
         check("rnd fill",  int'(b_fill),   q.size());
         check("rnd drop",  int'(b_drop),   int'(mdrop));
         check("rnd ovf",   int'(b_ovf),    int'(movf));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
